bram_rdstream: RTL and testbench
================================

Name: bram_rdstream

Overview:
- Read initiator for one port of the team's dual-port block RAM. It sits between that RAM's read port and a valid/ready stream consumer.
- Accepts a command (start address, word count), issues one-cycle-latency BRAM reads and streams the words out in order, with a last flag.
- Honours downstream backpressure without losing words. Sustains one word per cycle when the sink is always ready.
- Typical use: draining frame/table buffers written through the RAM's other port.

Parameters:
- SZ, 2, depth of the attached BRAM in words; sets address width AW = clog2(SZ).
- DW, 32, data width in bits; must match the BRAM.

Ports:
- clk_i  in  1  single clock; also clocks the attached BRAM port.
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  block idle, command can be accepted.
- cmd_addr_i  in  AW  first word address.
- cmd_len_i  in  AW+1  number of words to read, 0..SZ.
- bram_en_o  out  1  read enable to the BRAM port.
- bram_addr_o  out  AW  read address to the BRAM port.
- bram_data_i  in  DW  BRAM read data, valid the cycle after bram_en_o.
- data_o  out  DW  stream data.
- data_valid_o  out  1  stream word valid.
- data_ready_i  in  1  sink accepts the word.
- data_last_o  out  1  current word is the final word of the command.
- done_o  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values (asserted asynchronously on rst_i):
  - bram_en_o=0, bram_addr_o=0, data_valid_o=0, data_last_o=0, done_o=0, data_o=0.
  - cmd_ready_o=0 while rst_i is high.
  - FIFO empty, all counters 0, state IDLE.
- States: IDLE, RUN.
- IDLE:
  - cmd_ready_o=1.
  - cmd_valid_i & cmd_ready_o accepts the command at edge T.
  - If len≠0: latch addr into the issue pointer, latch len into issue_cnt and out_cnt, go to RUN.
  - If len=0: stay IDLE and pulse done_o in cycle T+1. No BRAM access and no stream output.
- RUN:
  - cmd_ready_o=0. Commands are ignored.
- Issue rule, evaluated in each RUN cycle:
  - bram_en_o = (issue_cnt≠0) & (occ + pend − pop < 2).
  - occ: FIFO occupancy (0..2).
  - pend: read issued in the previous cycle, not yet captured (0/1).
  - pop: data_valid_o & data_ready_i.
  - bram_en_o is combinational from state; bram_addr_o is the issue pointer.
- On each issue:
  - The pointer increments, wrapping from SZ−1 to 0; SZ need not be a power of two.
  - issue_cnt decrements.
- Capture: data present on bram_data_i in the cycle after an issue is written into a 2-entry FIFO at the end of that cycle.
- Latency:
  - Command accepted at edge T: first bram_en_o in cycle T+1.
  - First data_valid_o in cycle T+3.
- Stream:
  - data_o/data_valid_o come from the FIFO head. They stay stable while valid & ~ready.
  - Words are never dropped or duplicated under any data_ready_i pattern.
  - Throughput is 1 word/cycle with data_ready_i held high.
- data_last_o = data_valid_o & (out_cnt==1).
  - out_cnt decrements on each pop.
- Completion: a pop with data_last_o pulses done_o in the next cycle and returns to IDLE.
  - cmd_ready_o rises in that same next cycle.
- Address wrap: a command whose range crosses SZ−1 continues at 0. len=SZ reads every word exactly once.
- Simultaneous capture and pop of the same FIFO slot: both take effect; occupancy is unchanged.
- Reset mid-RUN:
  - All state clears immediately and any outstanding read is discarded.
  - The first edge after rst_i deasserts cannot produce data_valid_o.

Test Plan:
- BRAM model preloaded u[i]=0x100+i, SZ=16, cmd addr=3 len=4, data_ready_i=1 -> stream 0x103, 0x104, 0x105, 0x106.
  - data_last_o only with 0x106.
  - First valid at T+3, four consecutive valid cycles, done_o at the cycle after the last pop.
- addr=14 len=4, SZ=16 -> stream 0x10E, 0x10F, 0x100, 0x101; bram_addr_o sequence 14, 15, 0, 1.
- SZ=12, addr=10 len=12 -> addresses 10, 11, 0..9; 12 words, each once.
- len=8 with data_ready_i random at 30% -> 8 words in order; data_o stable during stall; bram_en_o never asserted when occ+pend−pop=2.
- len=0 -> no bram_en_o, no data_valid_o, done_o one cycle after accept, cmd_ready_o stays 1.
- rst_i pulsed at the third word of a len=8 command -> outputs zero asynchronously; after release cmd_ready_o=1; a new command addr=0 len=2 yields 0x100, 0x101 only.

Source files
------------

// File: rtl/bram_rdstream.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rdstream
//  Description : Read initiator for one BRAM port. Accepts (addr, len)
//                commands, issues one-cycle-latency reads and streams the
//                words out over valid/ready with a last flag and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_rdstream #(
    parameter  int SZ = 2,
    parameter  int DW = 32,
    localparam int AW = (SZ > 1) ? $clog2(SZ) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [AW:0]   cmd_len_i,
    output logic          bram_en_o,
    output logic [AW-1:0] bram_addr_o,
    input  logic [DW-1:0] bram_data_i,
    output logic [DW-1:0] data_o,
    output logic          data_valid_o,
    input  logic          data_ready_i,
    output logic          data_last_o,
    output logic          done_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_ADDR_MAX = AW'(SZ - 1);
    localparam logic [AW-1:0] c_ADDR_ONE = AW'(1);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [AW:0]     r_issue_cnt;
    logic [AW:0]     r_out_cnt;
    logic            r_pend;
    logic [DW-1:0]   r_fifo [2];
    logic            r_wr_sel;
    logic            r_rd_sel;
    logic [1:0]      r_occ;
    logic            r_done;

    logic            w_cmd_ready;
    logic            w_issue;
    logic            w_accept;
    logic            w_len_zero;
    logic            w_pop;
    logic            w_last_pop;
    logic [2:0]      w_level;
    logic [2:0]      w_limit;

    assign w_len_zero   = (cmd_len_i == '0);
    assign w_accept     = cmd_valid_i & w_cmd_ready;
    assign data_valid_o = (r_occ != 2'd0);
    assign data_o       = r_fifo[r_rd_sel];
    assign data_last_o  = data_valid_o & (r_out_cnt == c_CNT_ONE);
    assign w_pop        = data_valid_o & data_ready_i;
    assign w_last_pop   = w_pop & data_last_o;
    // Words in flight or buffered must stay below the 2-entry FIFO capacity,
    // counting a same-cycle pop as freeing a slot.
    assign w_level      = {1'b0, r_occ} + {2'b00, r_pend};
    assign w_limit      = 3'd2 + {2'b00, w_pop};

    assign cmd_ready_o  = w_cmd_ready;
    assign bram_en_o    = w_issue;
    assign bram_addr_o  = r_ptr;
    assign done_o       = r_done;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state, command handshake and read-issue decision
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = ~rst_i;
                if (cmd_valid_i && !rst_i && !w_len_zero) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_issue = (r_issue_cnt != '0) && (w_level < w_limit);
                if (w_last_pop) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Address pointer, issue/output counters and read-pending flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr       <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_pend      <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (w_accept && !w_len_zero) begin
                r_ptr       <= cmd_addr_i;
                r_issue_cnt <= cmd_len_i;
                r_out_cnt   <= cmd_len_i;
            end else begin
                if (w_issue) begin
                    r_ptr       <= (r_ptr == c_ADDR_MAX) ? '0 : r_ptr + c_ADDR_ONE;
                    r_issue_cnt <= r_issue_cnt - c_CNT_ONE;
                end
                if (w_pop) r_out_cnt <= r_out_cnt - c_CNT_ONE;
            end
        end
    end

    // Two-entry FIFO capturing BRAM data one cycle after each issue
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            if (r_pend) begin
                r_fifo[r_wr_sel] <= bram_data_i;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_pop) r_rd_sel <= ~r_rd_sel;
            case ({r_pend, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Completion pulse: after the last pop, or right after a zero-length command
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_done <= 1'b0;
        else       r_done <= (w_accept & w_len_zero) | w_last_pop;
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_rdstream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_rdstream
//  Description : Randomized self-checking bench for bram_rdstream; one
//                instance with SZ=16 and one with SZ=12, each with a BRAM
//                model, checked against a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_rdstream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [3:0]  cmd_addr  [2];
    logic [4:0]  cmd_len   [2];
    logic        en        [2];
    logic [3:0]  baddr     [2];
    logic [31:0] rdata     [2];
    logic [31:0] dat       [2];
    logic        dvalid    [2];
    logic        drdy      [2];
    logic        dlast     [2];
    logic        done      [2];
    logic [31:0] mem       [16];

    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;

    // reference model state, per instance
    int          ea         [2][16];
    int          mlen       [2];
    int          issued     [2];
    int          popped     [2];
    int          acc_cyc    [2];
    int          done_cyc   [2];
    bit          active     [2];
    bit          first_seen [2];
    bit          prev_stall [2];
    bit          full_rdy   [2];
    logic [31:0] prev_data  [2];

    bram_rdstream #(.SZ(16), .DW(32)) u_dut16 (
        .clk_i(clk), .rst_i(rst[0]),
        .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
        .cmd_addr_i(cmd_addr[0]), .cmd_len_i(cmd_len[0]),
        .bram_en_o(en[0]), .bram_addr_o(baddr[0]), .bram_data_i(rdata[0]),
        .data_o(dat[0]), .data_valid_o(dvalid[0]), .data_ready_i(drdy[0]),
        .data_last_o(dlast[0]), .done_o(done[0])
    );

    bram_rdstream #(.SZ(12), .DW(32)) u_dut12 (
        .clk_i(clk), .rst_i(rst[1]),
        .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
        .cmd_addr_i(cmd_addr[1]), .cmd_len_i(cmd_len[1]),
        .bram_en_o(en[1]), .bram_addr_o(baddr[1]), .bram_data_i(rdata[1]),
        .data_o(dat[1]), .data_valid_o(dvalid[1]), .data_ready_i(drdy[1]),
        .data_last_o(dlast[1]), .done_o(done[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // one-cycle-latency BRAM read ports
    always @(posedge clk) begin
        if (en[0]) rdata[0] <= mem[baddr[0]];
        if (en[1]) rdata[1] <= mem[baddr[1]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sz_of(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    // reference model / monitor, sampled on the falling edge
    always @(negedge clk) begin
        bit pop;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                chk("rst_valid", 32'(dvalid[k]), 0);
                chk("rst_en", 32'(en[k]), 0);
                chk("rst_cmd_ready", 32'(cmd_ready[k]), 0);
                chk("rst_data", dat[k], 0);
                active[k]     = 1'b0;
                done_cyc[k]   = -1;
                issued[k]     = 0;
                popped[k]     = 0;
                mlen[k]       = 0;
                first_seen[k] = 1'b0;
                prev_stall[k] = 1'b0;
            end else begin
                pop = dvalid[k] & drdy[k];
                chk("cmd_ready", 32'(cmd_ready[k]), 32'(!active[k]));
                chk("done", 32'(done[k]), 32'(cyc == done_cyc[k]));
                if (!active[k]) begin
                    chk("idle_en", 32'(en[k]), 0);
                    chk("idle_valid", 32'(dvalid[k]), 0);
                end
                if (en[k]) begin
                    chk("en_count", 32'(issued[k] < mlen[k]), 1);
                    chk("en_window", 32'((issued[k] - popped[k] - int'(pop)) < 2), 1);
                    if (issued[k] == 0) chk("en_latency", cyc, acc_cyc[k]);
                    if (issued[k] < 16) chk("bram_addr", 32'(baddr[k]), ea[k][issued[k]]);
                    issued[k]++;
                end
                if (active[k] && full_rdy[k] && first_seen[k] && popped[k] < mlen[k])
                    chk("throughput", 32'(dvalid[k]), 1);
                if (dvalid[k]) begin
                    if (!first_seen[k]) begin
                        chk("valid_latency", cyc, acc_cyc[k] + 2);
                        first_seen[k] = 1'b1;
                    end
                    if (prev_stall[k]) chk("stall_hold", dat[k], prev_data[k]);
                    chk("word_in_range", 32'(popped[k] < mlen[k]), 1);
                    if (popped[k] < mlen[k]) begin
                        chk("data", dat[k], 32'h100 + ea[k][popped[k]]);
                        chk("last", 32'(dlast[k]), 32'(popped[k] == mlen[k] - 1));
                    end
                end
                prev_stall[k] = dvalid[k] & ~drdy[k];
                prev_data[k]  = dat[k];
                if (pop) begin
                    popped[k]++;
                    if (popped[k] == mlen[k]) begin
                        done_cyc[k] = cyc + 1;
                        active[k]   = 1'b0;
                    end
                end
                if (cmd_valid[k] && cmd_ready[k]) begin
                    mlen[k]       = int'(cmd_len[k]);
                    for (int i = 0; i < 16; i++)
                        ea[k][i] = (int'(cmd_addr[k]) + i) % sz_of(k);
                    acc_cyc[k]    = cyc + 1;
                    issued[k]     = 0;
                    popped[k]     = 0;
                    first_seen[k] = 1'b0;
                    prev_stall[k] = 1'b0;
                    if (mlen[k] == 0) done_cyc[k] = cyc + 1;
                    else              active[k]   = 1'b1;
                end
            end
        end
    end

    task automatic wait_cmd_ready(input int k);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!cmd_ready[k] && n < 50);
        if (!cmd_ready[k]) chk("cmd_ready_timeout", 0, 1);
    endtask

    task automatic run_cmd(input int k, input int a, input int l, input int pct);
        int n;
        wait_cmd_ready(k);
        full_rdy[k]  = (pct >= 100);
        drdy[k]      = ($urandom_range(99) < pct);
        cmd_addr[k]  = a[3:0];
        cmd_len[k]   = l[4:0];
        cmd_valid[k] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[k] = 1'b0;
        n = 0;
        while (n < 400) begin
            drdy[k] = ($urandom_range(99) < pct);
            @(negedge clk);
            if (done[k]) break;
            @(posedge clk); #1;
            n++;
        end
        if (!done[k]) chk("done_timeout", 0, 1);
        full_rdy[k] = 1'b0;
    endtask

    initial begin
        int n, k, a, l, p;
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_addr[i] = '0;
            cmd_len[i] = '0; drdy[i] = 1'b0; full_rdy[i] = 1'b0;
            done_cyc[i] = -1; active[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #3;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        run_cmd(0, 3, 4, 100);      // plain stream
        run_cmd(0, 14, 4, 100);     // wrap through 15 -> 0
        run_cmd(1, 10, 12, 100);    // non-power-of-two depth, full range
        run_cmd(0, 9, 8, 30);       // heavy backpressure
        run_cmd(0, 7, 0, 100);      // zero-length command

        // reset while the third word is at the stream output
        wait_cmd_ready(0);
        full_rdy[0] = 1'b1; drdy[0] = 1'b1;
        cmd_addr[0] = 4'd5; cmd_len[0] = 5'd8; cmd_valid[0] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        n = 0;
        while (popped[0] < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_setup_pops", popped[0], 2);
        #1 rst[0] = 1'b1;
        #1;
        chk("async_rst_valid", 32'(dvalid[0]), 0);
        chk("async_rst_en", 32'(en[0]), 0);
        chk("async_rst_addr", 32'(baddr[0]), 0);
        chk("async_rst_data", dat[0], 0);
        chk("async_rst_last", 32'(dlast[0]), 0);
        chk("async_rst_done", 32'(done[0]), 0);
        chk("async_rst_cmd_ready", 32'(cmd_ready[0]), 0);
        full_rdy[0] = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst[0] = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready[0]), 1);
        run_cmd(0, 0, 2, 100);

        // random commands on both instances
        for (int i = 0; i < 14; i++) begin
            k = int'($urandom_range(1));
            a = int'($urandom_range(sz_of(k) - 1));
            l = int'($urandom_range(sz_of(k)));
            p = int'($urandom_range(100, 20));
            run_cmd(k, a, l, p);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
